// File: rtl/topob_feed_arb.sv
// Round-robin arbiter granting one feed lane per accept into a single registered TOB message slot.
// Define TOPOB_ARB_STATS_EN to add per-lane accept counters and an output-stall counter.
`ifndef TS_W
`define TS_W 48
`endif

module topob_feed_arb #(
  parameter int N_LANES = 4,
  parameter int LANE_W  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_LANES-1:0]    lane_valid,
  input  logic [64*N_LANES-1:0] lane_word0,
  input  logic [64*N_LANES-1:0] lane_word1,
  output logic [N_LANES-1:0]    lane_ready,
  input  logic [`TS_W-1:0]      ts_now,
`ifdef TOPOB_ARB_STATS_EN
  output logic [32*N_LANES-1:0] stat_grants,
  output logic [31:0]           stat_stall,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [63:0]           out_word0,
  output logic [63:0]           out_word1,
  output logic [LANE_W-1:0]     out_lane,
  output logic [`TS_W-1:0]      out_ts
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t            state, state_next;
  logic [LANE_W-1:0] rr_ptr;
  logic [LANE_W-1:0] grant_idx;
  logic              grant_found;
  logic              can_accept;
  logic              accept;

  // Search upward from rr_ptr with wrap; the first valid lane found wins.
  always_comb begin
    logic [LANE_W:0] cand;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 0; i < N_LANES; i++) begin
      cand = {1'b0, rr_ptr} + (LANE_W+1)'(i);
      if (cand >= (LANE_W+1)'(N_LANES)) cand = cand - (LANE_W+1)'(N_LANES);
      if (!grant_found && lane_valid[cand[LANE_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[LANE_W-1:0];
      end
    end
  end

  assign can_accept = (state == EMPTY) || out_ready;
  assign accept     = grant_found && can_accept && !rst;
  assign out_valid  = (state == FULL);

  always_comb begin
    lane_ready = '0;
    if (accept) lane_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    state_next = state;
    if (accept) state_next = FULL;
    else if ((state == FULL) && out_ready) state_next = EMPTY;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_next;
  end

  // A refill in the same cycle as a drain simply overwrites the slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_word0 <= '0;
      out_word1 <= '0;
      out_lane  <= '0;
      out_ts    <= '0;
      rr_ptr    <= '0;
    end else if (accept) begin
      out_word0 <= lane_word0[64*grant_idx +: 64];
      out_word1 <= lane_word1[64*grant_idx +: 64];
      out_lane  <= grant_idx;
      out_ts    <= ts_now;
      rr_ptr    <= (grant_idx == LANE_W'(N_LANES-1)) ? '0 : grant_idx + 1'b1;
    end
  end

`ifdef TOPOB_ARB_STATS_EN
  logic [31:0] grant_cnt [N_LANES];

  // Grant counters wrap naturally; the stall counter saturates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_LANES; i++) grant_cnt[i] <= '0;
      stat_stall <= '0;
    end else begin
      if (accept) grant_cnt[grant_idx] <= grant_cnt[grant_idx] + 32'd1;
      if ((state == FULL) && !out_ready && (stat_stall != 32'hFFFF_FFFF))
        stat_stall <= stat_stall + 32'd1;
    end
  end

  always_comb begin
    stat_grants = '0;
    for (int i = 0; i < N_LANES; i++) stat_grants[32*i +: 32] = grant_cnt[i];
  end
`endif

endmodule

// File: tb/tb_topob_feed_arb.sv
// Bench for topob_feed_arb: directed scenarios plus randomized traffic against a queue-free behavioural model.
`timescale 1ns/1ps
`ifndef TS_W
`define TS_W 48
`endif

module tb_topob_feed_arb;

  localparam int N  = 4;
  localparam int LW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      lane_valid;
  logic [64*N-1:0]   lane_word0;
  logic [64*N-1:0]   lane_word1;
  logic [N-1:0]      lane_ready;
  logic [`TS_W-1:0]  ts_now = 48'h0000_0000_1000;
  logic              out_valid;
  logic              out_ready;
  logic [63:0]       out_word0;
  logic [63:0]       out_word1;
  logic [LW-1:0]     out_lane;
  logic [`TS_W-1:0]  out_ts;
`ifdef TOPOB_ARB_STATS_EN
  logic [32*N-1:0]   stat_grants;
  logic [31:0]       stat_stall;
`endif

  topob_feed_arb #(.N_LANES(N), .LANE_W(LW)) dut (
    .clk        (clk),
    .rst        (rst),
    .lane_valid (lane_valid),
    .lane_word0 (lane_word0),
    .lane_word1 (lane_word1),
    .lane_ready (lane_ready),
    .ts_now     (ts_now),
`ifdef TOPOB_ARB_STATS_EN
    .stat_grants(stat_grants),
    .stat_stall (stat_stall),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_word0  (out_word0),
    .out_word1  (out_word1),
    .out_lane   (out_lane),
    .out_ts     (out_ts)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ts_now <= ts_now + 1'b1;

  int checks = 0;
  int errors = 0;

  // Behavioural model: one message slot, a round-robin start index, and counters.
  bit               m_full;
  logic [63:0]      m_w0, m_w1;
  int               m_lane;
  logic [`TS_W-1:0] m_ts;
  int               m_rr;
  int unsigned      m_grants [N];
  int unsigned      m_stall;

  function automatic int model_grant();
    if (rst) return -1;
    if (m_full && !out_ready) return -1;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_rr + k) % N;
      if (lane_valid[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(int g);
    logic [N-1:0] r;
    r = '0;
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    m_full = 1'b0;
    m_w0 = '0;
    m_w1 = '0;
    m_lane = 0;
    m_ts = '0;
    m_rr = 0;
    m_stall = 0;
    for (int i = 0; i < N; i++) m_grants[i] = 0;
  endtask

  task automatic set_lane(int i, logic [63:0] w0, logic [63:0] w1);
    lane_word0[64*i +: 64] = w0;
    lane_word1[64*i +: 64] = w1;
  endtask

  // Advance one clock and apply the accept/drain rules to the model.
  task automatic tick();
    int               g;
    logic [`TS_W-1:0] tsv;
    bit               stall;
    g     = model_grant();
    tsv   = ts_now;
    stall = m_full && !out_ready && !rst;
    @(posedge clk);
    if (g >= 0) begin
      m_full = 1'b1;
      m_w0   = lane_word0[64*g +: 64];
      m_w1   = lane_word1[64*g +: 64];
      m_lane = g;
      m_ts   = tsv;
      m_rr   = (g + 1) % N;
      m_grants[g]++;
    end else if (m_full && out_ready) begin
      m_full = 1'b0;
    end
    if (stall && m_stall != 32'hFFFF_FFFF) m_stall++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    lane_valid = '0;
    out_ready = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    lane_valid = '1;
    out_ready = 1'b1;
    lane_word0 = '0;
    lane_word1 = '0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_word0 !== 64'h0) begin errors++; $display("[TB] FAIL reset_word0: got %h expected 0", out_word0); end
    checks++; if (out_word1 !== 64'h0) begin errors++; $display("[TB] FAIL reset_word1: got %h expected 0", out_word1); end
    checks++; if (out_lane !== 2'd0) begin errors++; $display("[TB] FAIL reset_lane: got %0d expected 0", out_lane); end
    checks++; if (out_ts !== '0) begin errors++; $display("[TB] FAIL reset_ts: got %h expected 0", out_ts); end
    checks++; if (lane_ready !== 4'b0000) begin errors++; $display("[TB] FAIL reset_lane_ready: got %b expected 0000", lane_ready); end
    @(negedge clk);
    lane_valid = '0;
    rst = 1'b0;
    model_reset();
    #1;
  endtask

  task automatic test_single_lane();
    logic [`TS_W-1:0] tsv;
    do_reset();
    set_lane(2, 64'h0005_0000_1F40_0007, 64'h0000_0006_0000_1F41);
    lane_valid = 4'b0100;
    out_ready = 1'b1;
    #1;
    checks++; if (lane_ready !== 4'b0100) begin errors++; $display("[TB] FAIL single_ready: got %b expected 0100", lane_ready); end
    tsv = ts_now;
    tick();
    lane_valid = 4'b0000;
    #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_valid: got %b expected 1", out_valid); end
    checks++; if (out_lane !== 2'd2) begin errors++; $display("[TB] FAIL single_lane: got %0d expected 2", out_lane); end
    checks++; if (out_word0 !== 64'h0005_0000_1F40_0007) begin errors++; $display("[TB] FAIL single_word0: got %h expected 0005_0000_1f40_0007", out_word0); end
    checks++; if (out_word1 !== 64'h0000_0006_0000_1F41) begin errors++; $display("[TB] FAIL single_word1: got %h expected 0000_0006_0000_1f41", out_word1); end
    checks++; if (out_ts !== tsv) begin errors++; $display("[TB] FAIL single_ts: got %h expected %h", out_ts, tsv); end
    lane_valid = 4'b1111;
    #1;
    checks++; if (lane_ready !== 4'b1000) begin errors++; $display("[TB] FAIL single_rr_next: got %b expected 1000", lane_ready); end
    lane_valid = 4'b0000;
    tick();
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_drain: got %b expected 0", out_valid); end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < N; i++) set_lane(i, {$urandom, $urandom}, {$urandom, $urandom});
    lane_valid = 4'b1111;
    out_ready = 1'b1;
    for (int c = 0; c < 9; c++) begin
      #1;
      checks++; if (lane_ready !== onehot(c % N)) begin errors++; $display("[TB] FAIL rr_grant: cycle %0d got %b expected %b", c, lane_ready, onehot(c % N)); end
      if (c > 0) begin
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL rr_valid: cycle %0d got %b expected 1", c, out_valid); end
        checks++; if (out_lane !== LW'((c - 1) % N)) begin errors++; $display("[TB] FAIL rr_lane: cycle %0d got %0d expected %0d", c, out_lane, (c - 1) % N); end
        checks++; if (out_word0 !== m_w0 || out_word1 !== m_w1) begin errors++; $display("[TB] FAIL rr_payload: got %h/%h expected %h/%h", out_word0, out_word1, m_w0, m_w1); end
      end
      tick();
      set_lane(c % N, {$urandom, $urandom}, {$urandom, $urandom});
    end
    lane_valid = '0;
    tick();
  endtask

  task automatic test_back_to_back_stall();
    logic [63:0] l3_w0;
    do_reset();
    set_lane(0, 64'h1111_2222_3333_0000, 64'h0000_4444_5555_6666);
    l3_w0 = 64'h7777_8888_9999_0003;
    set_lane(3, l3_w0, 64'h0000_AAAA_BBBB_CCCC);
    lane_valid = 4'b1001;
    out_ready = 1'b1;
    #1;
    checks++; if (lane_ready !== 4'b0001) begin errors++; $display("[TB] FAIL stall_first: got %b expected 0001", lane_ready); end
    tick();
    set_lane(0, 64'hDEAD_BEEF_0000_0000, 64'h0);
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (lane_ready !== 4'b0000) begin errors++; $display("[TB] FAIL stall_ready: cycle %0d got %b expected 0000", c, lane_ready); end
      checks++; if (out_valid !== 1'b1 || out_lane !== 2'd0 || out_word0 !== 64'h1111_2222_3333_0000) begin
        errors++; $display("[TB] FAIL stall_hold: cycle %0d got v=%b lane=%0d w0=%h expected v=1 lane=0 w0=1111222233330000", c, out_valid, out_lane, out_word0);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    checks++; if (lane_ready !== 4'b1000) begin errors++; $display("[TB] FAIL stall_release: got %b expected 1000", lane_ready); end
    tick();
    lane_valid = '0;
    #1;
    checks++; if (out_lane !== 2'd3 || out_word0 !== l3_w0) begin errors++; $display("[TB] FAIL stall_lane3: got lane=%0d w0=%h expected lane=3 w0=%h", out_lane, out_word0, l3_w0); end
    tick();
  endtask

  task automatic test_wrap();
    do_reset();
    set_lane(2, 64'h2, 64'h2);
    set_lane(1, 64'h0000_0001_0000_0001, 64'h1);
    lane_valid = 4'b0100;
    out_ready = 1'b1;
    tick();
    lane_valid = 4'b0010;
    #1;
    checks++; if (lane_ready !== 4'b0010) begin errors++; $display("[TB] FAIL wrap_grant: got %b expected 0010", lane_ready); end
    tick();
    lane_valid = 4'b1111;
    #1;
    checks++; if (lane_ready !== 4'b0100) begin errors++; $display("[TB] FAIL wrap_rr_next: got %b expected 0100", lane_ready); end
    lane_valid = '0;
    tick();
  endtask

  task automatic test_async_reset();
    do_reset();
    set_lane(1, 64'hABCD_0000_0000_0001, 64'h5);
    lane_valid = 4'b0010;
    out_ready = 1'b0;
    tick();
    lane_valid = '0;
    #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL async_full: got %b expected 1", out_valid); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL async_valid_drop: got %b expected 0", out_valid); end
    checks++; if (out_lane !== 2'd0 || out_word0 !== 64'h0) begin errors++; $display("[TB] FAIL async_clear: got lane=%0d w0=%h expected 0/0", out_lane, out_word0); end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    set_lane(0, 64'h0, 64'h0);
    lane_valid = 4'b0011;
    out_ready = 1'b1;
    #1;
    checks++; if (lane_ready !== 4'b0001) begin errors++; $display("[TB] FAIL async_rr_restart: got %b expected 0001", lane_ready); end
    lane_valid = '0;
    tick();
  endtask

  task automatic test_random();
    bit pending [N];
    int g;
    do_reset();
    for (int i = 0; i < N; i++) pending[i] = 1'b0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pending[i] && $urandom_range(0, 2) == 0) begin
          pending[i] = 1'b1;
          set_lane(i, {$urandom, $urandom}, {$urandom, $urandom});
        end
        lane_valid[i] = pending[i];
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      g = model_grant();
      checks++; if (lane_ready !== onehot(g)) begin errors++; $display("[TB] FAIL rand_grant: cycle %0d got %b expected %b", c, lane_ready, onehot(g)); end
      checks++; if (out_valid !== m_full) begin errors++; $display("[TB] FAIL rand_valid: cycle %0d got %b expected %b", c, out_valid, m_full); end
      if (m_full) begin
        checks++;
        if (out_word0 !== m_w0 || out_word1 !== m_w1 || out_lane !== LW'(m_lane) || out_ts !== m_ts) begin
          errors++; $display("[TB] FAIL rand_msg: cycle %0d got %h/%h lane %0d ts %h expected %h/%h lane %0d ts %h", c, out_word0, out_word1, out_lane, out_ts, m_w0, m_w1, m_lane, m_ts);
        end
      end
      tick();
      if (g >= 0) pending[g] = 1'b0;
    end
`ifdef TOPOB_ARB_STATS_EN
    #1;
    checks++; if (stat_stall !== m_stall) begin errors++; $display("[TB] FAIL rand_stall_cnt: got %0d expected %0d", stat_stall, m_stall); end
    for (int i = 0; i < N; i++) begin
      checks++; if (stat_grants[32*i +: 32] !== m_grants[i]) begin errors++; $display("[TB] FAIL rand_grant_cnt: lane %0d got %0d expected %0d", i, stat_grants[32*i +: 32], m_grants[i]); end
    end
`endif
    lane_valid = '0;
    out_ready = 1'b1;
    tick();
  endtask

`ifdef TOPOB_ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    set_lane(1, 64'h1, 64'h1);
    lane_valid = 4'b0010;
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) tick();
    lane_valid = '0;
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) tick();
    out_ready = 1'b1;
    tick();
    #1;
    checks++; if (stat_grants[63:32] !== 32'd10) begin errors++; $display("[TB] FAIL stats_lane1: got %0d expected 10", stat_grants[63:32]); end
    checks++; if (stat_stall !== 32'd3) begin errors++; $display("[TB] FAIL stats_stall: got %0d expected 3", stat_stall); end
    checks++; if (stat_grants[31:0] !== 32'd0 || stat_grants[127:64] !== 64'd0) begin errors++; $display("[TB] FAIL stats_others: got %h expected 0", stat_grants); end
  endtask
`endif

  initial begin
    rst = 1'b1;
    lane_valid = '0;
    out_ready = 1'b0;
    model_reset();
    $display("[TB] starting topob_feed_arb bench");
    test_reset();
    test_single_lane();
    test_round_robin();
    test_back_to_back_stall();
    test_wrap();
    test_async_reset();
    test_random();
`ifdef TOPOB_ARB_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/topob_feed_arb.md
Name: topob_feed_arb

Overview:
- Round-robin arbiter sharing the single top-of-book unpack/strategy datapath between N_LANES feed-handler lanes.
- Each lane presents one two-word TOB message:
  - word0 = {bid_sz[63:48], bid_px[47:16], inst_id[15:0]}
  - word1 = {ask_sz[47:32], ask_px[31:0]}
- Grants one lane per accept, registers the message with its lane index and ingress timestamp, and drives it downstream under valid/ready backpressure.
- Sits between the per-port feed decoders and the TOB unpack stage.

Parameters:
- N_LANES, 4, number of requesting lanes (2..16).
- LANE_W, 2, width of the lane index; must equal clog2(N_LANES).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- lane_valid  input  N_LANES  per-lane message valid
- lane_word0  input  64*N_LANES  lane i word0 at [64*i+63:64*i]
- lane_word1  input  64*N_LANES  lane i word1, same packing
- lane_ready  output  N_LANES  per-lane accept (one-hot or zero)
- ts_now  input  `TS_W  free-running timestamp
- out_valid  output  1  output message valid
- out_ready  input  1  downstream ready
- out_word0  output  64  granted word0
- out_word1  output  64  granted word1
- out_lane  output  LANE_W  index of granted lane
- out_ts  output  `TS_W  ts_now sampled at accept

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values:
  - out_valid=0; out_word0, out_word1, out_lane and out_ts=0.
  - rr_ptr=0, state=EMPTY.
  - lane_ready=0 while rst is asserted.
- States:
  - EMPTY: output register empty; out_valid=0.
  - FULL: output register holds a message; out_valid=1.
- Accept condition: can_accept = (state==EMPTY) || (out_ready).
  - A register in FULL with out_ready=1 drains and refills in the same cycle.
  - Back-to-back throughput is one message per clk.
- Grant: combinational.
  - Select the first lane with lane_valid=1, searching upward from rr_ptr with wrap (rr_ptr, rr_ptr+1 mod N_LANES, ...).
  - lane_ready[g]=1 only when can_accept; all other bits are 0.
  - With no valid lanes, or can_accept=0, lane_ready is all-zero.
- On accept (lane_valid[g] && lane_ready[g]) at edge k:
  - Output registers capture the word0/word1 slices of lane g, out_lane=g, out_ts=ts_now.
  - state=FULL at k+1.
  - rr_ptr <= (g+1) mod N_LANES, with wrap from N_LANES-1 to 0.
- Other transitions:
  - FULL with out_ready=1 and no accept -> EMPTY at next edge; out_valid=0.
  - FULL with out_ready=0: hold all outputs stable; rr_ptr unchanged; lane_ready=0.
- Latency: accept edge to out_valid is 1 cycle; input-to-output adds no other cycles.
- Lane-side rules:
  - Lanes must hold lane_valid and their words stable until accepted.
  - The arbiter never grants a lane with lane_valid=0.
  - A lane dropping valid before grant loses nothing inside the arbiter.
- Fairness: a continuously valid lane is granted within N_LANES accepts.
- Reset asserted mid-operation: the held message is discarded, out_valid falls immediately (asynchronous), and rr_ptr returns to 0.
- The output side never generates or corrupts payload bits: the out_word0/out_word1 fields are bit-exact copies of the input.

Optional Feature:
- Macro: TOPOB_ARB_STATS_EN.
- Defined:
  - Adds an output stat_grants of width 32*N_LANES: a per-lane 32-bit accept counter incrementing on each accept of that lane, wrapping at 2^32-1 -> 0.
  - Adds an output stat_stall of width 32: counts cycles with state==FULL && out_ready==0, saturating at 2^32-1.
  - All counters reset to 0.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then lane2 only valid with word0=64'h0005_0000_1F40_0007 -> lane_ready=4'b0100 in the same cycle; next cycle out_valid=1, out_lane=2, out_word0 matches, out_ts=ts_now at accept; rr_ptr=3.
- All 4 lanes valid continuously, out_ready=1 -> grant order 0,1,2,3,0,1,... with one accept per cycle and out_valid constantly 1.
- Lanes 0 and 3 valid, out_ready=0 for 5 cycles after first accept -> outputs frozen and lane_ready=0 for 5 cycles; on out_ready=1, lane 3 is accepted in the same cycle.
- rr_ptr=3 with only lane 1 valid -> wraps and grants lane 1; rr_ptr becomes 2.
- rst asserted while FULL -> out_valid=0 asynchronously, before the next clk; after release, a lane-0/lane-1 contention grants lane 0 first.
- TOPOB_ARB_STATS_EN defined, 10 accepts on lane 1 and 3 stalled cycles -> stat_grants[63:32]=10 and stat_stall=3.
